// File: rtl/cascade_mod_counter_if.sv
// rtl/cascade_mod_counter_if.sv - control, load and count signals of the cascaded modulo counter
interface cascade_mod_counter_if #(
  parameter int N      = 4,
  parameter int DIGITS = 3
);
  logic                e;
  logic                run;
  logic                up;
  logic                load;
  logic [N*DIGITS-1:0] d;
  logic [N*DIGITS-1:0] q;
  logic                carry;
  logic                wrap;

  modport master (
    output e, run, up, load, d,
    input  q, carry, wrap
  );

  modport slave (
    input  e, run, up, load, d,
    output q, carry, wrap
  );
endinterface

// File: rtl/cascade_mod_counter.sv
// rtl/cascade_mod_counter.sv - DIGITS-stage modulo-K up/down counter with same-cycle carry and wrap pulse
module cascade_mod_counter #(
  parameter int N      = 4,
  parameter int K      = 10,
  parameter int DIGITS = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  cascade_mod_counter_if.slave bus
);
  localparam int              W    = N * DIGITS;
  localparam logic [N-1:0]    TOP  = N'(K - 1);
  localparam logic [N:0]      MODK = (N + 1)'(K);

  logic [W-1:0] q_r;
  logic [W-1:0] nxt_q;
  logic [W-1:0] ld_q;
  logic [N-1:0] cur;
  logic [N-1:0] ld_dig;
  logic         step;
  logic         chain;
  logic         tc;
  logic         carry;
  logic         wrap_r;

  // chain is high while every lower digit sits at its terminal value,
  // so all digits that must move do so on the same edge.
  always_comb begin
    step   = bus.run & bus.e & ~bus.load;
    nxt_q  = q_r;
    ld_q   = '0;
    cur    = '0;
    ld_dig = '0;
    tc     = 1'b0;
    chain  = step;
    for (int i = 0; i < DIGITS; i++) begin
      cur = q_r[N*i +: N];
      tc  = bus.up ? (cur == TOP) : (cur == '0);
      if (chain) begin
        if (bus.up)
          nxt_q[N*i +: N] = tc ? '0 : cur + 1'b1;
        else
          nxt_q[N*i +: N] = tc ? TOP : cur - 1'b1;
      end
      chain  = chain & tc;
      ld_dig = bus.d[N*i +: N];
      ld_q[N*i +: N] = ({1'b0, ld_dig} < MODK) ? ld_dig : '0;
    end
    carry = chain;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= carry;
      if (bus.load)
        q_r <= ld_q;
      else
        q_r <= nxt_q;
    end
  end

  assign bus.q     = q_r;
  assign bus.carry = carry;
  assign bus.wrap  = wrap_r;
endmodule

// File: tb/tb_cascade_mod_counter.sv
// tb/tb_cascade_mod_counter.sv - directed and random checks of cascade_mod_counter against an integer model
module tb_cascade_mod_counter;
  localparam int N      = 4;
  localparam int K      = 10;
  localparam int DIGITS = 3;
  localparam int W      = N * DIGITS;
  localparam int M      = K ** DIGITS;

  logic clk = 1'b0;
  logic resetn;
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_val       = 0;
  logic m_wrap      = 1'b0;

  always #5 clk = ~clk;

  cascade_mod_counter_if #(.N(N), .DIGITS(DIGITS)) bus ();

  cascade_mod_counter #(.N(N), .K(K), .DIGITS(DIGITS)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // The model holds the whole count as one integer in 0..K**DIGITS-1.
  function automatic logic [W-1:0] enc(input int v);
    logic [W-1:0] r;
    int           p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[N*i +: N] = N'((v / p) % K);
      p = p * K;
    end
    return r;
  endfunction

  function automatic int sanitize(input logic [W-1:0] dv);
    int s;
    int p;
    int dg;
    s = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      dg = int'(dv[N*i +: N]);
      s  = s + ((dg < K) ? dg : 0) * p;
      p  = p * K;
    end
    return s;
  endfunction

  function automatic logic exp_carry(input int v, input logic run, input logic e,
                                     input logic load, input logic up);
    if (!(run && e && !load)) return 1'b0;
    return up ? (v == M - 1) : (v == 0);
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_val  <= 0;
      m_wrap <= 1'b0;
    end else begin
      m_wrap <= exp_carry(m_val, bus.run, bus.e, bus.load, bus.up);
      if (bus.load)
        m_val <= sanitize(bus.d);
      else if (bus.run && bus.e)
        m_val <= bus.up ? (m_val + 1) % M : (m_val + M - 1) % M;
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("q", bus.q, enc(m_val));
    check("carry", W'(bus.carry), W'(exp_carry(m_val, bus.run, bus.e, bus.load, bus.up)));
    check("wrap", W'(bus.wrap), W'(m_wrap));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic load, input logic run, input logic e,
                       input logic up, input logic [W-1:0] dv);
    bus.load = load;
    bus.run  = run;
    bus.e    = e;
    bus.up   = up;
    bus.d    = dv;
  endtask

  initial begin
    logic [W-1:0] rd;
    int           sel;
    resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    repeat (2) tick();
    check("reset_q", bus.q, 12'h000);
    check("reset_wrap", W'(bus.wrap), W'(1'b0));

    resetn = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, '0);
    repeat (999) tick();
    check("full_up_q", bus.q, 12'h999);
    check("full_up_carry", W'(bus.carry), W'(1'b1));
    tick();
    check("full_up_wrapq", bus.q, 12'h000);
    check("full_up_wrap", W'(bus.wrap), W'(1'b1));
    bus.e = 1'b0;
    tick();
    check("wrap_one_cycle", W'(bus.wrap), W'(1'b0));

    drive(1'b1, 1'b1, 1'b1, 1'b1, 12'h019);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, '0);
    #1 check("q019_carry", W'(bus.carry), W'(1'b0));
    tick();
    check("q019_step", bus.q, 12'h020);

    drive(1'b1, 1'b0, 1'b0, 1'b1, 12'h000);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0);
    #1 check("down_carry", W'(bus.carry), W'(1'b1));
    tick();
    bus.e = 1'b0;
    check("down_q", bus.q, 12'h999);
    check("down_wrap", W'(bus.wrap), W'(1'b1));

    drive(1'b1, 1'b1, 1'b1, 1'b1, 12'h5F3);
    #1 check("load_carry", W'(bus.carry), W'(1'b0));
    tick();
    check("load_sanitize", bus.q, 12'h503);
    check("load_wrap", W'(bus.wrap), W'(1'b0));

    drive(1'b1, 1'b0, 1'b0, 1'b1, 12'h099);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) begin
      bus.e = 1'b1;
      #1 check("hold_carry", W'(bus.carry), W'(1'b0));
      tick();
      bus.e = 1'b0;
      tick();
    end
    check("hold_q", bus.q, 12'h099);
    drive(1'b0, 1'b1, 1'b1, 1'b1, '0);
    tick();
    bus.e = 1'b0;
    check("run_after_hold", bus.q, 12'h100);

    drive(1'b1, 1'b0, 1'b0, 1'b1, 12'h456);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, '0);
    tick();
    check("pre_reset_q", bus.q, 12'h457);
    #2 resetn = 1'b0;
    #1 check("async_reset_q", bus.q, 12'h000);
    check("async_reset_wrap", W'(bus.wrap), W'(1'b0));
    tick();
    resetn = 1'b1;
    repeat (3) tick();
    check("post_reset_q", bus.q, 12'h003);

    for (int c = 0; c < 3000; c++) begin
      sel = int'($urandom_range(0, 3));
      rd  = W'($urandom);
      if (sel == 0) rd = 12'h999;
      if (sel == 1) rd = 12'h000;
      drive(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
            ($urandom % 2) != 0, rd);
      resetn = !(($urandom % 250) == 0);
      tick();
    end
    resetn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
